// File: rtl/booth_r4_mul_seq.sv
// ---------------------------------------------------------------------------
// booth_r4_mul_seq
//
// Sequential radix-4 Booth multiplier with its own control FSM.
// The two N-bit operands arrive as four N/2-bit beats on in_bus.
// The product is computed two multiplier bits per clock.
// The result is registered as a 2N-bit product together with an overflow flag.
//
// Parameters
//   N            operand width (even, >= 4)
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active-low
//   start        begin a new operation (accepted in IDLE only)
//   signed_mode  1 = two's-complement, 0 = unsigned (latched on start)
//   in_valid     qualifies an in_bus beat while loading
//   in_bus       operand half-word: A lo, A hi, X lo, X hi
//   busy         high while loading operands or calculating
//   done         one-cycle pulse when product/ovf become valid
//   product      2N-bit result, held until the next accepted start
//   ovf          result does not fit in N bits for the latched mode
//   acc, acc_clr running sum of products and its clear
//                (only when BOOTH_ACC_EN is defined)
//
// Optional feature macro: BOOTH_ACC_EN
// ---------------------------------------------------------------------------
module booth_r4_mul_seq #(
    parameter int N = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic             in_valid,
    input  logic [N/2-1:0]   in_bus,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   product,
    output logic             ovf
`ifdef BOOTH_ACC_EN
    ,
    output logic [2*N-1:0]   acc,
    input  logic             acc_clr
`endif
);

    localparam int CNT_W = $clog2(N/2+2);

    typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [1:0]       beat;
    logic [CNT_W-1:0] iter_cnt;
    logic             mode_signed;
    logic [N-1:0]     a_reg;
    logic [N/2-1:0]   x_lo;
    logic [N+2:0]     a_ext;
    logic [N+1:0]     p_reg;
    logic [N+1:0]     x_reg;
    logic             x_guard;

    logic             load_last;
    logic             calc_last;
    logic [N-1:0]     x_full;
    logic [2:0]       triplet;
    logic [N+2:0]     addend;
    logic [N+2:0]     sum;
    logic [2*N-1:0]   final_prod;
    logic             final_ovf;

    assign load_last = (state == LOAD) && in_valid && (beat == 2'd3);
    assign calc_last = (state == CALC) && (iter_cnt == CNT_W'(1));
    assign x_full    = {in_bus, x_lo};

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and busy flag
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                busy = 1'b1;
                if (load_last) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (calc_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Booth recoding of the current multiplier triplet. The add is done
    // one bit wider than P. In unsigned mode, P + 2A can exceed the signed
    // range of N+2 bits. The shifted result always fits back into N+2 bits.
    always_comb begin
        triplet = {x_reg[1], x_reg[0], x_guard};
        addend  = '0;
        case (triplet)
            3'b001, 3'b010: addend = a_ext;
            3'b011:         addend = a_ext << 1;
            3'b100:         addend = -(a_ext << 1);
            3'b101, 3'b110: addend = -a_ext;
            default:        addend = '0;
        endcase
        sum = {p_reg[N+1], p_reg} + addend;
    end

    // Result extraction.
    // Signed mode retires only N bits of X, so the product sits two places
    // higher in {P,X}. Unsigned mode retires all N+2 bits.
    always_comb begin
        final_prod = '0;
        final_ovf  = 1'b0;
        if (mode_signed) begin
            final_prod = {p_reg[N-1:0], x_reg[N+1:2]};
            final_ovf  = !((&final_prod[2*N-1:N-1]) || !(|final_prod[2*N-1:N-1]));
        end else begin
            final_prod = {p_reg[N-3:0], x_reg};
            final_ovf  = |final_prod[2*N-1:N];
        end
    end

    // Datapath: operand capture, iteration, and result registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            beat        <= '0;
            iter_cnt    <= '0;
            mode_signed <= 1'b0;
            a_reg       <= '0;
            x_lo        <= '0;
            a_ext       <= '0;
            p_reg       <= '0;
            x_reg       <= '0;
            x_guard     <= 1'b0;
            product     <= '0;
            ovf         <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_signed <= signed_mode;
                        beat        <= '0;
                        product     <= '0;
                        ovf         <= 1'b0;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        beat <= beat + 2'd1;
                        case (beat)
                            2'd0: a_reg[N/2-1:0] <= in_bus;
                            2'd1: a_reg[N-1:N/2] <= in_bus;
                            2'd2: x_lo           <= in_bus;
                            default: begin
                                if (mode_signed) begin
                                    a_ext    <= {{3{a_reg[N-1]}}, a_reg};
                                    x_reg    <= {{2{x_full[N-1]}}, x_full};
                                    iter_cnt <= CNT_W'(N/2);
                                end else begin
                                    a_ext    <= {3'b000, a_reg};
                                    x_reg    <= {2'b00, x_full};
                                    iter_cnt <= CNT_W'(N/2+1);
                                end
                                p_reg   <= '0;
                                x_guard <= 1'b0;
                            end
                        endcase
                    end
                end
                CALC: begin
                    p_reg    <= {sum[N+2], sum[N+2:2]};
                    x_reg    <= {sum[1:0], x_reg[N+1:2]};
                    x_guard  <= x_reg[1];
                    iter_cnt <= iter_cnt - CNT_W'(1);
                end
                DONE: begin
                    product <= final_prod;
                    ovf     <= final_ovf;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef BOOTH_ACC_EN
    // Running sum of products. A clear that coincides with a completion
    // restarts the sum from that product.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc <= '0;
        end else if (acc_clr) begin
            acc <= (state == DONE) ? final_prod : '0;
        end else if (state == DONE) begin
            acc <= acc + final_prod;
        end
    end
`endif

endmodule

// File: tb/tb_booth_r4_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_booth_r4_mul_seq
//
// Self-checking bench for booth_r4_mul_seq with N = 16.
// Expected products come from plain 64-bit integer multiplication.
// Expected latencies come from the beat count plus the iteration count
// for the selected mode.
// ---------------------------------------------------------------------------
module tb_booth_r4_mul_seq;

    localparam int N = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          signed_mode;
    logic          in_valid;
    logic [N/2-1:0] in_bus;
    logic          busy;
    logic          done;
    logic [2*N-1:0] product;
    logic          ovf;
`ifdef BOOTH_ACC_EN
    logic [2*N-1:0] acc;
    logic          acc_clr;
`endif

    int checks   = 0;
    int failures = 0;

    logic [15:0] dir_a  [6] = '{16'h0003, 16'hFFF9, 16'hFFFF, 16'h8000, 16'hFFFF, 16'h1234};
    logic [15:0] dir_x  [6] = '{16'h0005, 16'h0006, 16'hFFFF, 16'h8000, 16'hFFFF, 16'h0000};
    bit          dir_sm [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    always #5 clk = ~clk;

    booth_r4_mul_seq #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .in_valid    (in_valid),
        .in_bus      (in_bus),
        .busy        (busy),
        .done        (done),
        .product     (product),
        .ovf         (ovf)
`ifdef BOOTH_ACC_EN
        ,
        .acc         (acc),
        .acc_clr     (acc_clr)
`endif
    );

    // Reference model: exact product of the operands as integers
    function automatic longint ref_full(input logic [15:0] a, input logic [15:0] x, input bit sm);
        longint pa;
        longint px;
        if (sm) begin
            pa = longint'($signed(a));
            px = longint'($signed(x));
        end else begin
            pa = longint'(a);
            px = longint'(x);
        end
        return pa * px;
    endfunction

    function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] x, input bit sm);
        logic [63:0] pv;
        pv = ref_full(a, x, sm);
        return pv[31:0];
    endfunction

    function automatic logic ref_ovf(input logic [15:0] a, input logic [15:0] x, input bit sm);
        longint p;
        p = ref_full(a, x, sm);
        if (sm) return (p < -32768) || (p > 32767);
        return p > 65535;
    endfunction

    // Cycles from the start edge until done is visible: 4 beats, the gap,
    // the iterations, and one cycle to register the result.
    function automatic int ref_total(input bit sm, input int gap);
        return 4 + gap + (sm ? N/2 : N/2 + 1) + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        start       = 1'b0;
        signed_mode = 1'b0;
        in_valid    = 1'b0;
        in_bus      = '0;
`ifdef BOOTH_ACC_EN
        acc_clr     = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Drives one complete operation.
    // A valid beat is asserted together with start; that beat must be ignored.
    // With noise set, start/in_valid/signed_mode are toggled during the
    // calculation. Returns when done is seen or the cycle budget expires.
    task automatic run_op(input logic [15:0] a, input logic [15:0] x, input bit sm,
                          input int gap, input bit noise,
                          output int total, output bit got_done);
        logic [7:0] beats [4];
        beats[0] = a[7:0];
        beats[1] = a[15:8];
        beats[2] = x[7:0];
        beats[3] = x[15:8];
        start       = 1'b1;
        signed_mode = sm;
        in_valid    = 1'b1;
        in_bus      = 8'hA5;
        tick();
        start = 1'b0;
        total = 0;
        for (int b = 0; b < 4; b++) begin
            in_valid = 1'b1;
            in_bus   = beats[b];
            tick();
            total++;
            if (b == 1) begin
                for (int g = 0; g < gap; g++) begin
                    in_valid = 1'b0;
                    in_bus   = 8'($urandom);
                    tick();
                    total++;
                end
            end
        end
        in_valid = 1'b0;
        got_done = 1'b0;
        for (int c = 0; c < 40 && !got_done; c++) begin
            if (noise) begin
                start       = 1'b1;
                in_valid    = 1'b1;
                in_bus      = 8'($urandom);
                signed_mode = ~sm;
            end
            tick();
            total++;
            if (done === 1'b1) got_done = 1'b1;
        end
        start       = 1'b0;
        in_valid    = 1'b0;
        signed_mode = sm;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_busy: got %b expected 0", busy);
        end
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_done: got %b expected 0", done);
        end
        checks++;
        if (product !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_product: got %h expected 00000000", product);
        end
        checks++;
        if (ovf !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ovf: got %b expected 0", ovf);
        end
    endtask

    task automatic test_directed();
        int  total;
        bit  got;
        for (int i = 0; i < 6; i++) begin
            run_op(dir_a[i], dir_x[i], dir_sm[i], 0, 1'b0, total, got);
            checks++;
            if (!got) begin
                failures++;
                $display("[TB] FAIL directed_timeout[%0d]: no done within budget", i);
            end
            checks++;
            if (total != ref_total(dir_sm[i], 0)) begin
                failures++;
                $display("[TB] FAIL directed_latency[%0d]: got %0d expected %0d", i, total, ref_total(dir_sm[i], 0));
            end
            checks++;
            if (product !== ref_prod(dir_a[i], dir_x[i], dir_sm[i])) begin
                failures++;
                $display("[TB] FAIL directed_product[%0d]: got %h expected %h", i, product, ref_prod(dir_a[i], dir_x[i], dir_sm[i]));
            end
            checks++;
            if (ovf !== ref_ovf(dir_a[i], dir_x[i], dir_sm[i])) begin
                failures++;
                $display("[TB] FAIL directed_ovf[%0d]: got %b expected %b", i, ovf, ref_ovf(dir_a[i], dir_x[i], dir_sm[i]));
            end
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("[TB] FAIL directed_pulse[%0d]: got done=%b busy=%b expected 0 0", i, done, busy);
            end
        end
    endtask

    task automatic test_gap();
        int total;
        bit got;
        run_op(16'h0003, 16'h0005, 1'b1, 3, 1'b0, total, got);
        checks++;
        if (!got || total != ref_total(1'b1, 3)) begin
            failures++;
            $display("[TB] FAIL gap_latency: got %0d (done seen %b) expected %0d", total, got, ref_total(1'b1, 3));
        end
        checks++;
        if (product !== 32'h0000000F) begin
            failures++;
            $display("[TB] FAIL gap_product: got %h expected 0000000f", product);
        end
    endtask

    task automatic test_busy_ignored();
        int total;
        bit got;
        run_op(16'hFFF9, 16'h0006, 1'b1, 1, 1'b1, total, got);
        checks++;
        if (!got || total != ref_total(1'b1, 1)) begin
            failures++;
            $display("[TB] FAIL busy_latency: got %0d (done seen %b) expected %0d", total, got, ref_total(1'b1, 1));
        end
        checks++;
        if (product !== 32'hFFFFFFD6 || ovf !== 1'b0) begin
            failures++;
            $display("[TB] FAIL busy_product: got %h/%b expected ffffffd6/0", product, ovf);
        end
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [15:0] x;
        bit          sm;
        bit          noise;
        int          gap;
        int          total;
        bit          got;
        for (int i = 0; i < 24; i++) begin
            a     = 16'($urandom);
            x     = 16'($urandom);
            sm    = 1'($urandom);
            noise = 1'($urandom);
            gap   = $urandom_range(0, 2);
            run_op(a, x, sm, gap, noise, total, got);
            checks++;
            if (!got || total != ref_total(sm, gap)) begin
                failures++;
                $display("[TB] FAIL random_latency[%0d]: got %0d (done seen %b) expected %0d", i, total, got, ref_total(sm, gap));
            end
            checks++;
            if (product !== ref_prod(a, x, sm) || ovf !== ref_ovf(a, x, sm)) begin
                failures++;
                $display("[TB] FAIL random_result[%0d]: a=%h x=%h s=%b got %h/%b expected %h/%b",
                         i, a, x, sm, product, ovf, ref_prod(a, x, sm), ref_ovf(a, x, sm));
            end
        end
    endtask

    task automatic test_reset_mid_calc();
        bit seen_done;
        start       = 1'b1;
        signed_mode = 1'b1;
        tick();
        start = 1'b0;
        for (int b = 0; b < 4; b++) begin
            in_valid = 1'b1;
            in_bus   = 8'h5A + 8'(b);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midcalc_busy: got %b expected 1", busy);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 32'h0 || ovf !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midcalc_reset: got busy=%b done=%b product=%h ovf=%b expected 0 0 0 0",
                     busy, done, product, ovf);
        end
        rst = 1'b1;
        seen_done = 1'b0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
        end
        checks++;
        if (seen_done) begin
            failures++;
            $display("[TB] FAIL midcalc_abandon: got activity after reset expected none");
        end
    endtask

    task automatic test_back_to_back();
        int total;
        bit got;
        run_op(16'h0003, 16'h0005, 1'b1, 0, 1'b0, total, got);
        run_op(16'h8000, 16'h8000, 1'b1, 0, 1'b0, total, got);
        checks++;
        if (!got || total != ref_total(1'b1, 0)) begin
            failures++;
            $display("[TB] FAIL b2b_latency: got %0d (done seen %b) expected %0d", total, got, ref_total(1'b1, 0));
        end
        checks++;
        if (product !== 32'h40000000 || ovf !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_result: got %h/%b expected 40000000/1", product, ovf);
        end
    endtask

    task automatic test_hold_and_clear();
        int total;
        bit got;
        run_op(16'hFFFF, 16'hFFFF, 1'b0, 0, 1'b0, total, got);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_bus   = 8'($urandom);
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (product !== 32'hFFFE0001 || ovf !== 1'b1) begin
            failures++;
            $display("[TB] FAIL hold_result: got %h/%b expected fffe0001/1", product, ovf);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (product !== 32'h0 || ovf !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL start_clear: got %h/%b busy=%b expected 00000000/0 busy=1", product, ovf, busy);
        end
        do_reset();
    endtask

`ifdef BOOTH_ACC_EN
    task automatic test_accumulate();
        int total;
        bit got;
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        checks++;
        if (acc !== 32'h0) begin
            failures++;
            $display("[TB] FAIL acc_clear: got %h expected 00000000", acc);
        end
        run_op(16'h0003, 16'h0005, 1'b1, 0, 1'b0, total, got);
        checks++;
        if (acc !== 32'h0000000F) begin
            failures++;
            $display("[TB] FAIL acc_first: got %h expected 0000000f", acc);
        end
        run_op(16'hFFF9, 16'h0006, 1'b1, 0, 1'b0, total, got);
        checks++;
        if (acc !== 32'hFFFFFFE5) begin
            failures++;
            $display("[TB] FAIL acc_second: got %h expected ffffffe5", acc);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_gap();
        test_busy_ignored();
        test_reset_mid_calc();
        test_random();
        test_back_to_back();
        test_hold_and_clear();
`ifdef BOOTH_ACC_EN
        test_accumulate();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
